// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Sits between a UART receiver/transmitter pair and the on-chip register bus.
// It builds command frames out of received bytes, runs each frame as one
// register-bus transaction, and sends back one response byte.
//
//   Write frame : 0xA5, addr, data  -> response 0x06 (ACK) once the bus acks
//   Read frame  : 0x5A, addr        -> response is the read data byte
//   Bad opcode or bus timeout       -> response 0x15 (NAK), err_cnt++
//   Inter-byte timeout              -> frame dropped silently, err_cnt++
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   rx_rdy, rx_data   receiver byte handshake (level, held until clr_rdy)
//   clr_rdy           combinational; high in the cycle a byte is consumed
//   trmt, tx_data     one-cycle transmit start, byte held until tx_done
//   tx_done           transmitter finished sending
//   reg_wr, reg_rd    bus request levels, held until reg_ack or timeout
//   reg_addr          bus address
//   reg_wdata         bus write data
//   reg_rdata         bus read data, sampled in the reg_ack cycle
//   reg_ack           one-cycle bus completion
//   busy              high whenever the sequencer is not idle
//   err_cnt           saturating count of protocol and bus errors
//
// Parameter
//   TIMEOUT_CYC       cycles allowed between frame bytes and for a bus ack
//                     (must be at least 2)
// -----------------------------------------------------------------------------
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       clr_rdy,
  output logic       trmt,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  input  logic       reg_ack,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] OP_WR   = 8'hA5;
  localparam logic [7:0] OP_RD   = 8'h5A;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  // The counter only ever reaches TIMEOUT_CYC-1 before the state changes and
  // clears it, so $clog2(TIMEOUT_CYC) bits are enough.
  localparam int              CW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS_WR,
    BUS_RD,
    SEND,
    WAIT_TX
  } state_e;

  state_e        state_q,   state_d;
  logic          is_wr_q,   is_wr_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [7:0]    addr_q,    addr_d;
  logic [7:0]    wdata_q,   wdata_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          trmt_q,    trmt_d;
  logic          reg_wr_q,  reg_wr_d;
  logic          reg_rd_q,  reg_rd_d;
  logic          busy_q,    busy_d;

  logic          tmo_fire;
  logic          err_inc;
  logic          counting;

  // Bytes are only taken while assembling a frame; during the bus access and
  // the response they stay pending in the receiver.
  assign clr_rdy = rx_rdy &&
                   ((state_q == IDLE) || (state_q == GET_ADDR) || (state_q == GET_DATA));

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_q;
    err_inc   = 1'b0;
    tmo_fire  = (tmo_cnt_q == TMO_LAST);

    case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          if (rx_data == OP_WR) begin
            state_d = GET_ADDR;
            is_wr_d = 1'b1;
          end else if (rx_data == OP_RD) begin
            state_d = GET_ADDR;
            is_wr_d = 1'b0;
          end else begin
            state_d   = SEND;
            tx_data_d = RSP_NAK;
            err_inc   = 1'b1;
          end
        end
      end

      // A byte arriving in the final allowed cycle beats the timeout.
      GET_ADDR: begin
        if (rx_rdy) begin
          addr_d  = rx_data;
          state_d = is_wr_q ? GET_DATA : BUS_RD;
        end else if (tmo_fire) begin
          state_d = IDLE;
          err_inc = 1'b1;
        end
      end

      GET_DATA: begin
        if (rx_rdy) begin
          wdata_d = rx_data;
          state_d = BUS_WR;
        end else if (tmo_fire) begin
          state_d = IDLE;
          err_inc = 1'b1;
        end
      end

      BUS_WR: begin
        if (reg_ack) begin
          state_d   = SEND;
          tx_data_d = RSP_ACK;
        end else if (tmo_fire) begin
          state_d   = SEND;
          tx_data_d = RSP_NAK;
          err_inc   = 1'b1;
        end
      end

      BUS_RD: begin
        if (reg_ack) begin
          state_d   = SEND;
          tx_data_d = reg_rdata;
        end else if (tmo_fire) begin
          state_d   = SEND;
          tx_data_d = RSP_NAK;
          err_inc   = 1'b1;
        end
      end

      SEND: begin
        state_d = WAIT_TX;
      end

      WAIT_TX: begin
        if (tx_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout counter: restart on any state change, run only while waiting
    // on the link or the bus.
    counting = (state_q == GET_ADDR) || (state_q == GET_DATA) ||
               (state_q == BUS_WR)   || (state_q == BUS_RD);
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (counting) begin
      tmo_cnt_d = tmo_cnt_q + CW'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end

    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end

    // Outputs are registered copies of what the next state implies, so they
    // line up with the state they belong to and carry no glitches.
    trmt_d   = (state_d == SEND);
    reg_wr_d = (state_d == BUS_WR);
    reg_rd_d = (state_d == BUS_RD);
    busy_d   = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_wr_q   <= 1'b0;
      tmo_cnt_q <= '0;
      err_cnt_q <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      tx_data_q <= 8'h00;
      trmt_q    <= 1'b0;
      reg_wr_q  <= 1'b0;
      reg_rd_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_cnt_q <= err_cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      trmt_q    <= trmt_d;
      reg_wr_q  <= reg_wr_d;
      reg_rd_q  <= reg_rd_d;
      busy_q    <= busy_d;
    end
  end

  assign trmt      = trmt_q;
  assign tx_data   = tx_data_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = busy_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
//
// Drives uart_cmd_ctrl as receiver, transmitter and register bus. Expected
// responses come from a frame-level model: a shadow register file updated by
// each accepted write frame, and a saturating error tally.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  localparam int TMO = 20;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_BAD = 2;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rdy;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       busy;
  logic [7:0] err_cnt;

  uart_cmd_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .clr_rdy   (clr_rdy),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         err_model = 0;
  logic [7:0] model_mem [256];   // what the frames say the registers hold
  logic [7:0] bus_mem   [256];   // register file behind the bus responder

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {7'd0, obs}, {7'd0, exp});
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Present one byte after 'gap' idle cycles and hold it until it is taken.
  task automatic push_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    n = 0;
    while (!clr_rdy && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_bit("byte_taken", clr_rdy, 1'b1);
    @(negedge clk);
    rx_rdy  = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // Entered on the first request cycle; acks after ack_dly cycles, or never
  // when ack_dly < 0. Returns on the cycle the response should be launched.
  task automatic finish_bus(input logic is_wr, input int ack_dly);
    if (ack_dly < 0) begin
      for (int i = 1; i < TMO; i++) @(negedge clk);
      check_bit("req_held_last_cycle", is_wr ? reg_wr : reg_rd, 1'b1);
      @(negedge clk);
    end else begin
      repeat (ack_dly) @(negedge clk);
      check_bit("req_before_ack", is_wr ? reg_wr : reg_rd, 1'b1);
      check_bit("other_req_low", is_wr ? reg_rd : reg_wr, 1'b0);
      reg_ack   = 1'b1;
      reg_rdata = bus_mem[reg_addr];
      if (reg_wr) bus_mem[reg_addr] = reg_wdata;
      @(negedge clk);
      reg_ack   = 1'b0;
      reg_rdata = 8'($urandom);
    end
    check_bit("reg_wr_dropped", reg_wr, 1'b0);
    check_bit("reg_rd_dropped", reg_rd, 1'b0);
  endtask

  // Entered on the SEND cycle; runs the transmitter handshake back to idle.
  task automatic finish_resp(input logic [7:0] exp, input int tx_dly);
    check_bit("trmt_pulse", trmt, 1'b1);
    check("tx_data", tx_data, exp);
    check_bit("busy_send", busy, 1'b1);
    #1 check_bit("no_take_send", clr_rdy, 1'b0);
    @(negedge clk);
    check_bit("trmt_one_cycle", trmt, 1'b0);
    repeat (tx_dly) @(negedge clk);
    #1 check_bit("no_take_wait", clr_rdy, 1'b0);
    check("tx_data_stable", tx_data, exp);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check_bit("idle_after_tx", busy, 1'b0);
    check("err_cnt", err_cnt, 8'(err_model));
  endtask

  task automatic run_frame(input int kind, input logic [7:0] a, input logic [7:0] d,
                           input int ack_dly, input int tx_dly, input int gap);
    logic [7:0] exp;
    if (kind == K_BAD) begin
      push_byte(a, gap);
      err_model = sat_inc(err_model);
      exp = NAK;
    end else begin
      push_byte((kind == K_WR) ? 8'hA5 : 8'h5A, gap);
      check_bit("busy_frame", busy, 1'b1);
      push_byte(a, gap);
      if (kind == K_WR) push_byte(d, gap);
      check_bit("reg_wr_req", reg_wr, kind == K_WR);
      check_bit("reg_rd_req", reg_rd, kind == K_RD);
      check("reg_addr", reg_addr, a);
      if (kind == K_WR) check("reg_wdata", reg_wdata, d);
      if (ack_dly < 0) begin
        exp = NAK;
        err_model = sat_inc(err_model);
      end else if (kind == K_WR) begin
        model_mem[a] = d;
        exp = ACK;
      end else begin
        exp = model_mem[a];
      end
      finish_bus(kind == K_WR, ack_dly);
    end
    finish_resp(exp, tx_dly);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of run");
    $fatal(1);
  end

  initial begin
    int         kind;
    int         ack;
    logic [7:0] a;
    logic [7:0] d;

    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'($urandom);
      bus_mem[i]   = model_mem[i];
    end

    // Reset state.
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
    reg_rdata = 8'h00; reg_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_trmt", trmt, 1'b0);
    check_bit("rst_reg_wr", reg_wr, 1'b0);
    check_bit("rst_reg_rd", reg_rd, 1'b0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_err_cnt", err_cnt, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check_bit("idle_clr_rdy", clr_rdy, 1'b0);

    // Stray ack / tx_done while idle do nothing.
    reg_ack = 1'b1; tx_done = 1'b1;
    @(negedge clk);
    reg_ack = 1'b0; tx_done = 1'b0;
    @(negedge clk);
    check_bit("stray_busy", busy, 1'b0);
    check_bit("stray_trmt", trmt, 1'b0);

    // Write A5 10 3C, ack after 3 cycles.
    run_frame(K_WR, 8'h10, 8'h3C, 3, 2, 0);
    check("write_err0", err_cnt, 8'h00);

    // Read 5A 22 returning 0x9B.
    model_mem[8'h22] = 8'h9B;
    bus_mem[8'h22]   = 8'h9B;
    run_frame(K_RD, 8'h22, 8'h00, 4, 1, 0);

    // Bad opcode, then a normal write.
    run_frame(K_BAD, 8'h77, 8'h00, 0, 0, 0);
    check("bad_err1", err_cnt, 8'h01);
    run_frame(K_WR, 8'h01, 8'h02, 0, 0, 0);

    // Silence after the address byte: dropped after TMO cycles, no response.
    push_byte(8'hA5, 0);
    push_byte(8'h10, 0);
    for (int i = 1; i < TMO; i++) begin
      @(negedge clk);
      check_bit("frame_wait_busy", busy, 1'b1);
      check_bit("frame_wait_trmt", trmt, 1'b0);
    end
    @(negedge clk);
    err_model = sat_inc(err_model);
    check_bit("frame_tmo_idle", busy, 1'b0);
    check_bit("frame_tmo_no_trmt", trmt, 1'b0);
    check("frame_tmo_err", err_cnt, 8'(err_model));

    // Silence after the opcode also times out.
    push_byte(8'h5A, 0);
    repeat (TMO) @(negedge clk);
    err_model = sat_inc(err_model);
    check_bit("addr_tmo_idle", busy, 1'b0);
    check("addr_tmo_err", err_cnt, 8'(err_model));

    // Data byte in the last allowed cycle wins over the timeout.
    push_byte(8'hA5, 0);
    push_byte(8'h10, 0);
    repeat (TMO - 1) @(negedge clk);
    push_byte(8'h44, 0);
    check_bit("late_byte_reg_wr", reg_wr, 1'b1);
    check("late_byte_err", err_cnt, 8'(err_model));
    model_mem[8'h10] = 8'h44;
    finish_bus(1'b1, TMO - 1);
    finish_resp(ACK, 0);

    // Read with no ack: request dropped after TMO cycles and NAK sent.
    run_frame(K_RD, 8'h05, 8'h00, -1, 1, 0);

    // Single-cycle ack; a byte arriving during the response waits.
    push_byte(8'hA5, 0);
    push_byte(8'h30, 0);
    push_byte(8'h55, 0);
    model_mem[8'h30] = 8'h55;
    finish_bus(1'b1, 0);
    rx_data = 8'h77;
    rx_rdy  = 1'b1;
    finish_resp(ACK, 2);
    #1 check_bit("pending_byte_taken", clr_rdy, 1'b1);
    @(negedge clk);
    rx_rdy = 1'b0;
    err_model = sat_inc(err_model);
    finish_resp(NAK, 0);

    // Reset in the middle of a bus write aborts without a response.
    push_byte(8'hA5, 0);
    push_byte(8'h40, 0);
    push_byte(8'h66, 0);
    check_bit("pre_rst_reg_wr", reg_wr, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_reg_wr", reg_wr, 1'b0);
    check_bit("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addr", reg_addr, 8'h00);
    check("mid_rst_err", err_cnt, 8'h00);
    err_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_bit("post_rst_no_trmt", trmt, 1'b0);
    end
    run_frame(K_WR, 8'h40, 8'h77, 1, 0, 0);
    run_frame(K_RD, 8'h40, 8'h00, 0, 0, 0);

    // Randomized frames against the model.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      a    = 8'($urandom);
      d    = 8'($urandom);
      ack  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
      if (kind == K_BAD) begin
        while (a == 8'hA5 || a == 8'h5A) a = 8'($urandom);
      end
      run_frame(kind, a, d, ack, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end

    // Error counter saturation.
    for (int n = 0; n < 260; n++) begin
      run_frame(K_BAD, 8'hFF, 8'h00, 0, 0, 0);
    end
    check("err_saturated", err_cnt, 8'hFF);
    run_frame(K_WR, 8'h7E, 8'hE7, 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer between the UART receiver/transmitter pair and the on-chip register bus. It consumes bytes from the receiver's `rx_data`/`rdy` handshake and assembles them into read or write command frames. It executes each frame as a single register-bus transaction, then returns one response byte through the UART transmitter. Inter-byte and bus-ack timeouts, plus a saturating error counter, keep a broken link from hanging the block.

## Interface
- `TIMEOUT_CYC`, default 5000: clk cycles allowed between frame bytes, and for a bus ack. Must be ≥2.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `rx_rdy`  in  1  receiver byte-ready level; stays high until `clr_rdy` is seen
- `rx_data`  in  8  received byte, valid while `rx_rdy`=1
- `clr_rdy`  out  1  combinational; high in the cycle a byte is consumed
- `trmt`  out  1  one-cycle transmit start pulse
- `tx_data`  out  8  byte to transmit; stable from `trmt` until `tx_done`
- `tx_done`  in  1  transmitter done; must be low by the cycle after `trmt`
- `reg_wr`  out  1  bus write request; level, held until ack
- `reg_rd`  out  1  bus read request; level, held until ack
- `reg_addr`  out  8  bus address
- `reg_wdata`  out  8  bus write data
- `reg_rdata`  in  8  bus read data, valid with `reg_ack`
- `reg_ack`  in  1  bus transaction complete, one cycle
- `busy`  out  1  high when state ≠ IDLE
- `err_cnt`  out  8  error count, saturates at 255

## Operation
- Frame formats:
  - Write: `0xA5`, addr, data.
  - Read: `0x5A`, addr.
- Responses:
  - Write success: `0x06` (ACK).
  - Read success: the read data byte.
  - Bad opcode or bus timeout: `0x15` (NAK).
  - Frame timeout: no response.
- States and transitions:
  - IDLE: byte with `0xA5` → GET_ADDR, write flag set. Byte with `0x5A` → GET_ADDR, read flag set. Any other byte → SEND with `0x15`, `err_cnt`++.
  - GET_ADDR: byte latched to `reg_addr`. Read → BUS_RD. Write → GET_DATA.
  - GET_DATA: byte latched to `reg_wdata` → BUS_WR.
  - BUS_WR: `reg_wr`=1 until `reg_ack`, then → SEND with `0x06`.
  - BUS_RD: `reg_rd`=1 until `reg_ack`, then → SEND with `reg_rdata` latched in the ack cycle.
  - SEND: `trmt`=1 for one cycle, then → WAIT_TX.
  - WAIT_TX: wait for `tx_done`=1, then → IDLE.
- Byte consumption: a byte is consumed when `rx_rdy`=1 in IDLE, GET_ADDR or GET_DATA. `clr_rdy` is asserted that same cycle.
- `rx_rdy` is ignored, and not cleared, in BUS_*, SEND and WAIT_TX. Bytes arriving during a response wait in the receiver.
- Timeout counter:
  - Cleared on every state transition; increments each cycle in GET_ADDR, GET_DATA, BUS_WR and BUS_RD.
  - Fires when count = TIMEOUT_CYC−1 and no byte/ack arrives that cycle.
  - In GET_*: timeout → IDLE, `err_cnt`++.
  - In BUS_*: timeout → SEND with `0x15`, request dropped, `err_cnt`++.
- Simultaneous byte/ack and timeout: the byte or ack wins and no error is counted.
- `err_cnt` holds at 255 once reached.

## Timing
- Reset values:
  - All outputs 0; state IDLE; counters 0.
  - `reg_addr`, `reg_wdata`, `tx_data` reset to 0x00.
- Reset mid-frame or mid-transaction aborts immediately; no response is sent.
- Byte consumed at cycle T → new state active at T+1.
- Last write-frame byte at T → `reg_wr` high from T+1.
- `reg_ack` at cycle A → `reg_wr`/`reg_rd` low at A+1 and `trmt` at A+1; WAIT_TX from A+2.
- `reg_ack` in the first request cycle is legal (single-cycle transaction).
- `tx_done` high at cycle D in WAIT_TX → IDLE at D+1; a new byte can be consumed at D+1.
- `reg_ack` outside BUS_* is ignored.
- `tx_done` outside WAIT_TX is ignored.

## Test plan
- Write `A5 10 3C` → `reg_wr`=1 with addr 0x10, wdata 0x3C. Ack after 3 cycles → `trmt` with `tx_data`=0x06. `err_cnt` stays 0.
- Read `5A 22`, with bus returning 0x9B on the ack cycle → `reg_rd` high until ack, then `trmt` with `tx_data`=0x9B. `reg_wr` never asserts.
- Bad opcode `0x77` → `0x15` transmitted, `err_cnt`=1, back to IDLE. A following `A5 01 02` then completes normally.
- `A5 10`, then silence, with TIMEOUT_CYC=20 → IDLE 20 cycles after the addr byte, no `trmt`, `err_cnt`=1. A byte arriving in the final cycle instead advances to BUS_WR with no error.
- `5A 05` with no `reg_ack` and TIMEOUT_CYC=20 → `reg_rd` drops after 20 cycles, `0x15` sent. Also: 260 bad opcodes → `err_cnt`=255.
- `rst_n` pulsed low during BUS_WR → all outputs 0 immediately, state IDLE, no response sent. The next frame succeeds.
